// File: rtl/braille_msg_scroller_pkg.sv
// rtl/braille_msg_scroller_pkg.sv - shared letter constants, state enum and letter check
package braille_pkg;

   localparam int LETTER_W   = 5;
   localparam int LETTER_MIN = 1;
   localparam int LETTER_MAX = 26;
   localparam logic [LETTER_W-1:0] BLANK = 5'd0;

   typedef enum logic {EDIT, SCROLL} state_t;

   function automatic logic is_letter(input logic [LETTER_W-1:0] code);
      return (code >= LETTER_W'(LETTER_MIN)) && (code <= LETTER_W'(LETTER_MAX));
   endfunction

endpackage

// File: rtl/braille_msg_scroller_if.sv
// rtl/braille_msg_scroller_if.sv - switch/key inputs and four-letter display bundle
interface braille_msg_scroller_if #(
   parameter int DEPTH = 16
) ();

   logic [4:0]                   SW;
   logic [3:0]                   KEY;
   logic [4:0]                   L0;
   logic [4:0]                   L1;
   logic [4:0]                   L2;
   logic [4:0]                   L3;
   logic [$clog2(DEPTH+1)-1:0]   count;
   logic                         full;
   logic                         scrolling;

   modport master (
      output SW, KEY,
      input  L0, L1, L2, L3, count, full, scrolling
   );

   modport slave (
      input  SW, KEY,
      output L0, L1, L2, L3, count, full, scrolling
   );

endinterface

// File: rtl/braille_msg_scroller_key_debounce.sv
// rtl/braille_msg_scroller_key_debounce.sv - sync, debounce and press-edge pulse for one active-low key
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic key,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

   logic          sync1;
   logic          sync2;
   logic          stable;
   logic          armed;
   logic [CW-1:0] cnt;

   // The synchronizer resets to "pressed" so a key held through reset is debounced
   // silently; pulses are only armed once a released level has actually been seen.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         stable <= 1'b1;
         armed  <= 1'b0;
         cnt    <= '0;
         press  <= 1'b0;
      end else begin
         sync1 <= key;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2)
            armed <= 1'b1;
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt    <= '0;
            stable <= sync2;
            press  <= armed & ~sync2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/braille_msg_scroller.sv
// rtl/braille_msg_scroller.sv - debounced letter message editor with four-digit scroll view
module braille_msg_scroller
   import braille_pkg::*;
#(
   parameter int DEPTH           = 16,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int TICK_DIV        = 25000000
) (
   input  logic                  CLOCK_50,
   input  logic                  reset,
   braille_msg_scroller_if.slave io
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PW = $clog2(DEPTH + 4) + 1;
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [3:0]          press;
   state_t              state, state_n;
   logic [CW-1:0]       count, count_n;
   logic [PW-1:0]       pos, pos_n;
   logic [PW-1:0]       len, len_n;
   logic [TW-1:0]       tick, tick_n;
   logic                we;
   logic [LETTER_W-1:0] mem  [DEPTH];
   logic [LETTER_W-1:0] view [DEPTH];
   logic [LETTER_W-1:0] disp   [4];
   logic [LETTER_W-1:0] disp_n [4];
   int                  idx;

   for (genvar i = 0; i < 4; i++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_key (
         .clk  (CLOCK_50),
         .reset(reset),
         .key  (io.KEY[i]),
         .press(press[i])
      );
   end

   assign len = PW'(count) + PW'(4);

   // Pulse priority is clear > toggle > delete > append; the scroll tick runs
   // independently of ignored edit pulses.
   always_comb begin
      state_n = state;
      count_n = count;
      pos_n   = pos;
      tick_n  = tick;
      we      = 1'b0;
      if (press[3]) begin
         state_n = EDIT;
         count_n = '0;
         pos_n   = '0;
         tick_n  = '0;
      end else if (press[2]) begin
         if (state == SCROLL) begin
            state_n = EDIT;
         end else if (count != '0) begin
            state_n = SCROLL;
            pos_n   = '0;
            tick_n  = '0;
         end
      end else if (state == EDIT) begin
         if (press[1]) begin
            if (count != '0)
               count_n = count - 1'b1;
         end else if (press[0]) begin
            if (is_letter(io.SW) && (count < CW'(DEPTH))) begin
               we      = 1'b1;
               count_n = count + 1'b1;
            end
         end
      end else begin
         if (tick == TW'(TICK_DIV - 1)) begin
            tick_n = '0;
            pos_n  = (pos == len - 1'b1) ? '0 : pos + 1'b1;
         end else begin
            tick_n = tick + 1'b1;
         end
      end
   end

   // Display is built from next-state values so it updates on the action edge.
   always_comb begin
      view   = mem;
      if (we)
         view[count[AW-1:0]] = io.SW;
      len_n  = PW'(count_n) + PW'(4);
      idx    = 0;
      disp_n = '{default: BLANK};
      for (int m = 0; m < 4; m++) begin
         if (state_n == EDIT) begin
            idx = int'(count_n) - 1 - m;
            if (idx >= 0)
               disp_n[m] = view[AW'(idx)];
         end else begin
            idx = int'(pos_n) + (3 - m);
            if (idx >= int'(len_n))
               idx = idx - int'(len_n);
            if (idx < int'(count_n))
               disp_n[m] = view[AW'(idx)];
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state <= EDIT;
         count <= '0;
         pos   <= '0;
         tick  <= '0;
         disp  <= '{default: BLANK};
      end else begin
         state <= state_n;
         count <= count_n;
         pos   <= pos_n;
         tick  <= tick_n;
         disp  <= disp_n;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!reset && we)
         mem[count[AW-1:0]] <= io.SW;
   end

   assign io.L0        = disp[0];
   assign io.L1        = disp[1];
   assign io.L2        = disp[2];
   assign io.L3        = disp[3];
   assign io.count     = count;
   assign io.full      = (count == CW'(DEPTH));
   assign io.scrolling = (state == SCROLL);

endmodule
